// File: rtl/gpio_bus_arbiter_pkg.sv
// gpio_arb_pkg: shared arbiter state type and default bank/requester sizes
package gpio_arb_pkg;
    typedef enum logic [1:0] {IDLE, OWN, TURN} arb_state_t;
    localparam int GPIO_W = 34;
    localparam int ARB_N_REQ = 4;
endpackage

// File: rtl/gpio_bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority encoder
//   req        requests, one bit per engine
//   last_owner previous owner; search starts just after it
//   valid      some request is pending
//   winner     index of the chosen requester
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_owner,
    output logic                 valid,
    output logic [$clog2(N)-1:0] winner
);
    localparam int IW = $clog2(N);
    always_comb begin
        valid = 1'b0;
        winner = '0;
        // scan furthest-first so the nearest requester after last_owner wins
        for (int i = N; i >= 1; i--) begin
            automatic logic [IW-1:0] k = IW'((int'(last_owner) + i) % N);
            if (req[k]) begin
                valid = 1'b1;
                winner = k;
            end
        end
    end
endmodule

// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: round-robin owner of the GPIO bank with turnaround and hold timeout
//   clk, rst          clock, synchronous active-high reset
//   en                chip enable; low forces idle with all pads as inputs
//   req               level request per engine
//   eng_out, eng_oeb  per-engine pad values and active-low enables
//   gnt, owner        registered one-hot grant and owner index
//   gpio_out/gpio_oeb pad outputs and active-low enables
module gpio_bus_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int N_REQ = ARB_N_REQ,
    parameter int WIDTH = GPIO_W,
    parameter int HOLD_MAX = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ-1:0][WIDTH-1:0]   eng_out,
    input  logic [N_REQ-1:0][WIDTH-1:0]   eng_oeb,
    output logic [N_REQ-1:0]              gnt,
    output logic [$clog2(N_REQ)-1:0]      owner,
    output logic [WIDTH-1:0]              gpio_out,
    output logic [WIDTH-1:0]              gpio_oeb
);
    localparam int OW = $clog2(N_REQ);
    localparam int CW = HOLD_MAX > 0 ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_TOP = HOLD_MAX > 0 ? CW'(HOLD_MAX - 1) : '0;
    arb_state_t state;
    logic [OW-1:0] last_owner;
    logic [CW-1:0] cnt;
    logic pick_valid;
    logic [OW-1:0] pick;
    logic release_now;
    rr_picker #(.N(N_REQ)) u_pick (
        .req        (req),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .winner     (pick)
    );
    // gnt is one-hot on the owner, so req & ~gnt are the competitors
    assign release_now = !req[owner] || (HOLD_MAX != 0 && cnt == CNT_TOP && |(req & ~gnt));
    assign gpio_out = state == OWN ? eng_out[owner] : '0;
    assign gpio_oeb = state == OWN ? eng_oeb[owner] : '1;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            last_owner <= OW'(N_REQ - 1);
            cnt <= '0;
            gnt <= '0;
        end else if (!en) begin
            state <= IDLE;
            cnt <= '0;
            gnt <= '0;
        end else begin
            case (state)
                IDLE, TURN: begin
                    state <= pick_valid ? OWN : IDLE;
                    cnt <= '0;
                    gnt <= pick_valid ? N_REQ'(1) << pick : '0;
                    if (pick_valid) begin
                        owner <= pick;
                        last_owner <= pick;
                    end
                end
                OWN: begin
                    state <= release_now ? TURN : OWN;
                    gnt <= release_now ? '0 : gnt;
                    cnt <= release_now ? '0 : (cnt == CNT_TOP ? cnt : cnt + 1'b1);
                end
                default: begin
                    state <= IDLE;
                    gnt <= '0;
                end
            endcase
        end
    end
endmodule
